// File: rtl/usb_uart_tx_pkg.sv
// Shared types and helpers for the USB-to-UART transmitter.
// Build option: define USB_UART_TX_PARITY_EN to append an even-parity bit to every frame.
package usb_uart_pkg;

`ifdef USB_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    localparam int FRAME_BITS = 10;
`endif

    localparam int DATA_BITS  = 8;
    localparam int BAUD_CNT_W = 16;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/usb_uart_tx_if.sv
// Byte handshake from the USB OUT endpoint receive side into the transmitter.
interface usb_uart_tx_if;
    logic       in_val;
    logic [7:0] in_dat;
    logic       in_rdy;

    modport master (output in_val, output in_dat, input in_rdy);
    modport slave  (input in_val, input in_dat, output in_rdy);
endinterface

// File: rtl/usb_uart_tx_fifo.sv
// Single-clock byte FIFO with occupancy count; storage is deliberately left unreset.
module usb_uart_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/usb_uart_tx.sv
// USB-to-UART transmit path: FIFO-fed 8N1 serialiser with registered line output.
// Build option: USB_UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module usb_uart_tx
    import usb_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 417,
    parameter int FIFO_DEPTH = 64,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    usb_uart_tx_if.slave       in_if,
    output logic               tx,
    output logic               busy,
    output logic [LVL_W-1:0]   level
);
    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);

    tx_state_t             state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  baud_done;
    logic                  push;
    logic                  fifo_pop;
    logic [7:0]            fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_count;

    assign in_if.in_rdy = !fifo_full;
    assign push         = in_if.in_val && in_if.in_rdy;
    assign baud_done    = (baud_q == '0);
    assign tx           = tx_q;
    assign level        = fifo_count;
    assign busy         = (state_q != S_IDLE) || (fifo_count != '0);

    usb_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CW    (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (in_if.in_dat),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The shift register rotates, so after eight bits it holds the original byte again.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_done ? BAUD_RELOAD : baud_q - 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = BAUD_RELOAD;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    shift_d = {shift_q[0], shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef USB_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef USB_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = S_START;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef USB_UART_TX_PARITY_EN
            S_PARITY: tx_d = even_parity(shift_q);
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end
endmodule

// File: doc/usb_uart_tx.md
USB_UART_TX -- requirements
Module: usb_uart_tx

Interface
- REQ-001 Parameter BAUD_DIV, default 417, clock cycles per serial bit; legal range 4..65535.
- REQ-002 Parameter FIFO_DEPTH, default 64, byte entries; power of two, 4..256.
- REQ-003 clk  input  1  sole clock, all state on its rising edge.
- REQ-004 rst  input  1  asynchronous, active-high reset.
- REQ-005 in_val  input  1  byte offered from USB OUT endpoint receive side.
- REQ-006 in_dat  input  8  offered byte.
- REQ-007 in_rdy  output  1  block can accept a byte this cycle.
- REQ-008 tx  output  1  serial line, idle high, registered.
- REQ-009 busy  output  1  frame in progress or FIFO non-empty.
- REQ-010 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
- REQ-011 A byte is accepted on a rising edge where in_val and in_rdy are both 1; no other edge accepts a byte.
- REQ-012 in_rdy = (level != FIFO_DEPTH), combinational from registered count; a pop in the same cycle does not raise in_rdy when full.
- REQ-013 Simultaneous push and pop: level unchanged, both operations take effect.
- REQ-014 Bytes are transmitted in acceptance order; none dropped, none duplicated.
- REQ-015 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- REQ-016 IDLE: tx=1; if FIFO non-empty, pop head into shift register and go to START on that edge.
- REQ-017 START: tx=0 for BAUD_DIV cycles, then DATA.
- REQ-018 DATA: 8 bits, LSB first, each held BAUD_DIV cycles; 3-bit counter, then PARITY or STOP.
- REQ-019 STOP: tx=1 for BAUD_DIV cycles, then IDLE; next frame may start the following edge (no extra idle bit).
- REQ-020 Latency: byte accepted at edge N into empty FIFO while IDLE -> tx first low in the cycle after edge N+2.
- REQ-021 Baud counter counts BAUD_DIV-1 down to 0, reloaded on every state/bit transition; 16-bit width.
- REQ-022 busy = (state != IDLE) || (level != 0).
- REQ-023 in_dat changes while in_val=1 and in_rdy=0 do not affect FIFO contents.

Reset
- REQ-024 On rst asserted: tx=1, state=IDLE, level=0, FIFO pointers=0, baud and bit counters=0, busy=0; in_rdy=1 after release.
- REQ-025 Reset mid-frame aborts the frame immediately (tx high asynchronously); queued bytes are discarded.
- REQ-026 FIFO storage array is not reset.

Configuration
- REQ-027 Macro USB_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = XOR of the 8 data bits (even parity) for BAUD_DIV cycles; frame = 11 bits.
- REQ-028 Macro undefined: no PARITY state, no parity logic; frame = 10 bits.

Structure
- REQ-029 Package usb_uart_pkg holds the FSM state enum, frame-length constants and an even-parity function.
- REQ-030 FIFO is a separate sub-module usb_uart_fifo (sync, single clock, same rst, push/pop/full/empty/count).
- REQ-031 usb_uart_tx contains only the FSM, baud counter, bit counter and shift register.

Verification (BAUD_DIV=8, FIFO_DEPTH=4)
- REQ-032 Push 0x55 into idle block at edge N -> tx low from cycle after N+2 for 8 cycles, then 1,0,1,0,1,0,1,0 each 8 cycles, stop high 8 cycles; frame 80 cycles (88 with parity, parity bit 0).
- REQ-033 Push 0x01,0x02,0x03,0x04,0x05 back-to-back with in_val held -> in_rdy drops when level=4, 0x05 accepted only after first pop; line decodes 01..05 in order, no idle gap between frames.
- REQ-034 Full FIFO with pop and in_val same cycle -> push refused that cycle, level becomes 3, next cycle push accepted.
- REQ-035 Assert rst during DATA bit 3 of 0xA5 with 2 bytes queued -> tx=1 same cycle, level=0, busy=0; after release no further frames emitted.
- REQ-036 With USB_UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
- REQ-037 Idle for 1000 cycles after reset with in_val=0 -> tx constant 1, busy=0, level=0.
